// File: rtl/pulser_pkg.sv
// Shared state encodings and default timing constants for button_pulser.
// State set depends on the REPEAT_EN macro.
package pulser_pkg;

    localparam int          CW_DEFAULT   = 26;
    localparam logic [25:0] HOLD_DEFAULT = 26'd50_000_000;
    localparam logic [25:0] RATE_DEFAULT = 26'd10_000_000;

`ifdef REPEAT_EN
    typedef enum logic [1:0] {
        ST_IDLE   = 2'b00,
        ST_DELAY  = 2'b01,
        ST_REPEAT = 2'b10
    } state_t;
`else
    typedef enum logic [1:0] {
        ST_IDLE    = 2'b00,
        ST_PRESSED = 2'b01
    } state_t;
`endif

endpackage

// File: rtl/pulser_channel.sv
// One button channel: press edge detect plus optional hold/auto-repeat timing.
// REPEAT_EN selects the IDLE/DELAY/REPEAT machine; otherwise IDLE/PRESSED only.
module pulser_channel
    import pulser_pkg::*;
#(
`ifdef REPEAT_EN
    parameter int          CW   = CW_DEFAULT,
    parameter logic [CW-1:0] HOLD = CW'(HOLD_DEFAULT),
    parameter logic [CW-1:0] RATE = CW'(RATE_DEFAULT)
`endif
) (
    input  logic clk,
    input  logic rst,
    input  logic i,
    output logic y,
    output logic h
);

    state_t state, state_n;
    logic   i_q;
    logic   y_n;

`ifdef REPEAT_EN
    localparam logic [CW-1:0] HOLD_M1 = HOLD - 1'b1;
    localparam logic [CW-1:0] RATE_M1 = RATE - 1'b1;

    logic [CW-1:0] count, count_n;

    // Release is checked before the terminal count so a release always wins.
    always_comb begin
        state_n = state;
        count_n = count;
        y_n     = 1'b0;
        case (state)
            ST_IDLE: begin
                if (i && !i_q) begin
                    y_n     = 1'b1;
                    count_n = '0;
                    state_n = ST_DELAY;
                end
            end
            ST_DELAY: begin
                if (!i) begin
                    state_n = ST_IDLE;
                end else if (count == HOLD_M1) begin
                    y_n     = 1'b1;
                    count_n = '0;
                    state_n = ST_REPEAT;
                end else begin
                    count_n = count + 1'b1;
                end
            end
            ST_REPEAT: begin
                if (!i) begin
                    state_n = ST_IDLE;
                end else if (count == RATE_M1) begin
                    y_n     = 1'b1;
                    count_n = '0;
                end else begin
                    count_n = count + 1'b1;
                end
            end
            default: begin
                state_n = ST_IDLE;
                count_n = '0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_IDLE;
            count <= '0;
            i_q   <= 1'b0;
            y     <= 1'b0;
            h     <= 1'b0;
        end else begin
            state <= state_n;
            count <= count_n;
            i_q   <= i;
            y     <= y_n;
            h     <= (state_n == ST_REPEAT);
        end
    end
`else
    always_comb begin
        state_n = state;
        y_n     = 1'b0;
        case (state)
            ST_IDLE: begin
                if (i && !i_q) begin
                    y_n     = 1'b1;
                    state_n = ST_PRESSED;
                end
            end
            ST_PRESSED: begin
                if (!i) begin
                    state_n = ST_IDLE;
                end
            end
            default: state_n = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_IDLE;
            i_q   <= 1'b0;
            y     <= 1'b0;
        end else begin
            state <= state_n;
            i_q   <= i;
            y     <= y_n;
        end
    end

    assign h = 1'b0;
`endif

endmodule

// File: rtl/button_pulser.sv
// W independent button channels turning debounced levels into move strobes.
// Define REPEAT_EN for hold-to-auto-repeat; without it only press edges pulse.
module button_pulser
    import pulser_pkg::*;
#(
    parameter int W = 5
`ifdef REPEAT_EN
    ,
    parameter int            CW   = CW_DEFAULT,
    parameter logic [CW-1:0] HOLD = CW'(HOLD_DEFAULT),
    parameter logic [CW-1:0] RATE = CW'(RATE_DEFAULT)
`endif
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [W-1:0] I,
    output logic [W-1:0] Y,
    output logic [W-1:0] H
);

    for (genvar g = 0; g < W; g++) begin : g_ch
        pulser_channel #(
`ifdef REPEAT_EN
            .CW   (CW),
            .HOLD (HOLD),
            .RATE (RATE)
`endif
        ) u_ch (
            .clk (clk),
            .rst (rst),
            .i   (I[g]),
            .y   (Y[g]),
            .h   (H[g])
        );
    end

endmodule
